// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the ALU execute stage: alu_op classes, funct3/funct7 codes, FSM states.
package alu_pkg;

  localparam logic [1:0] R_T = 2'b10;
  localparam logic [1:0] I_T = 2'b11;
  localparam logic [1:0] S_T = 2'b00;
  localparam logic [1:0] B_T = 2'b01;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNC7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between register-read and the ALU execute stage.
interface alu_exec_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic            branch;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            illegal;

  modport master (
    output in_valid, alu_op, func3, func7, branch, a, b,
    input  in_ready, out_valid, result, branch_taken, illegal
  );

  modport slave (
    input  in_valid, alu_op, func3, func7, branch, a, b,
    output in_ready, out_valid, result, branch_taken, illegal
  );
endinterface

// File: rtl/alu_exec_unit_muldiv_iter.sv
// Radix-2 iterative multiply/divide: shift-add multiply, restoring divide, on magnitudes
// with sign correction on the final step. done is high in the cycle whose edge completes the op.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi_p0, lo_p0, opnd_p0;
  logic [2:0]      op_p0;
  logic            neg_p0, neg_r_p0;

  logic            a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   sum, sh;
  logic [XLEN-1:0] diff, nhi, nlo, q_c, r_c;
  logic            ge;
  logic [2*XLEN-1:0] prod, prod_c;

  always_comb begin
    a_sgn = (op == F3_MUL) || (op == F3_MULH) || (op == F3_MULHSU) ||
            (op == F3_DIV) || (op == F3_REM);
    b_sgn = (op == F3_MUL) || (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    sa    = a_sgn & a[XLEN-1];
    sb    = b_sgn & b[XLEN-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // One iteration: multiply adds then shifts right, divide shifts left then trial-subtracts.
  always_comb begin
    sum  = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, opnd_p0} : '0);
    sh   = {hi_p0, lo_p0[XLEN-1]};
    ge   = sh >= {1'b0, opnd_p0};
    diff = sh[XLEN-1:0] - opnd_p0;
    if (op_p0[2]) begin
      nhi = ge ? diff : sh[XLEN-1:0];
      nlo = {lo_p0[XLEN-2:0], ge};
    end else begin
      nhi = sum[XLEN:1];
      nlo = {sum[0], lo_p0[XLEN-1:1]};
    end
    prod   = {nhi, nlo};
    prod_c = neg_p0 ? -prod : prod;
    q_c    = neg_p0 ? -nlo : nlo;
    r_c    = neg_r_p0 ? -nhi : nhi;
    case (op_p0)
      F3_MUL:                      result = prod_c[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod_c[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             result = q_c;
      default:                     result = r_c;
    endcase
  end

  assign done = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(XLEN - 1);
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

  // p0: operand/accumulator registers; a zero divisor keeps the all-ones quotient unsigned
  always_ff @(posedge clk) begin
    if (start) begin
      op_p0    <= op;
      hi_p0    <= '0;
      lo_p0    <= op[2] ? mag_a : mag_b;
      opnd_p0  <= op[2] ? mag_b : mag_a;
      neg_p0   <= (sa ^ sb) & (!op[2] || (b != '0));
      neg_r_p0 <= sa;
    end else if (busy) begin
      hi_p0 <= nhi;
      lo_p0 <= nlo;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered RV32 execute stage: ALU decode/execute, branch resolution, optional iterative
// M-extension engine enabled by defining ALU_MULDIV_EN.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst,
  alu_exec_unit_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  state_t          state_q, state_d;
  logic            accept, is_m, md_start, md_done;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] res_c;
  logic            taken_c, ill_c, cond, m_enc;
  logic            vld_p1, taken_p1, ill_p1;
  logic [XLEN-1:0] res_p1;

  function automatic logic [XLEN-1:0] alu_fn(input logic [2:0] f3, input logic sub,
                                             input logic arith, input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
    logic signed [XLEN-1:0] xs, ys;
    xs = x;
    ys = y;
    case (f3)
      F3_ADD:  return sub ? x - y : x + y;
      F3_SLL:  return x << y[SHW-1:0];
      F3_SLT:  return {{(XLEN-1){1'b0}}, xs < ys};
      F3_SLTU: return {{(XLEN-1){1'b0}}, x < y};
      F3_XOR:  return x ^ y;
      F3_SR:   return arith ? XLEN'(xs >>> y[SHW-1:0]) : x >> y[SHW-1:0];
      F3_OR:   return x | y;
      default: return x & y;
    endcase
  endfunction

  assign accept = bus.in_valid & bus.in_ready;
  assign m_enc  = (bus.alu_op == R_T) && (bus.func7 == FUNC7_MULDIV);

  always_comb begin
    res_c   = '0;
    taken_c = 1'b0;
    ill_c   = 1'b0;
    cond    = 1'b0;
    is_m    = 1'b0;
    case (bus.alu_op)
      S_T: res_c = bus.a + bus.b;
      B_T: begin
        res_c = bus.a - bus.b;
        case (bus.func3)
          F3_BEQ:  cond = bus.a == bus.b;
          F3_BNE:  cond = bus.a != bus.b;
          F3_BLT:  cond = $signed(bus.a) < $signed(bus.b);
          F3_BGE:  cond = $signed(bus.a) >= $signed(bus.b);
          F3_BLTU: cond = bus.a < bus.b;
          F3_BGEU: cond = bus.a >= bus.b;
          default: ill_c = 1'b1;
        endcase
        taken_c = bus.branch & cond;
      end
      default: begin
        if (m_enc) begin
`ifdef ALU_MULDIV_EN
          is_m = 1'b1;
`else
          ill_c = 1'b1;
`endif
        end else if ((bus.alu_op == R_T) && !((bus.func7 == FUNC7_BASE) ||
                     ((bus.func7 == FUNC7_ALT) &&
                      ((bus.func3 == F3_ADD) || (bus.func3 == F3_SR))))) begin
          ill_c = 1'b1;
        end else begin
          // I-type has no SUBI: the immediate's bit 5 only matters for shifts.
          res_c = alu_fn(bus.func3, (bus.alu_op == R_T) && bus.func7[5], bus.func7[5],
                         bus.a, bus.b);
        end
      end
    endcase
    if (ill_c) begin
      res_c   = '0;
      taken_c = 1'b0;
    end
  end

  assign md_start = accept & is_m;

`ifdef ALU_MULDIV_EN
  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op     (bus.func3),
    .a      (bus.a),
    .b      (bus.b),
    .done   (md_done),
    .result (md_result)
  );
  assign bus.in_ready = (state_q == IDLE);
`else
  assign md_done      = 1'b0;
  assign md_result    = '0;
  assign bus.in_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md_start) state_d = BUSY;
      BUSY:    if (md_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // p1: registered outputs, out_valid pulses for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      taken_p1 <= 1'b0;
      ill_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (accept && !is_m) begin
        vld_p1   <= 1'b1;
        res_p1   <= res_c;
        taken_p1 <= taken_c;
        ill_p1   <= ill_c;
      end else if (md_done) begin
        vld_p1   <= 1'b1;
        res_p1   <= md_result;
        taken_p1 <= 1'b0;
        ill_p1   <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = vld_p1;
  assign bus.result       = res_p1;
  assign bus.branch_taken = taken_p1;
  assign bus.illegal      = ill_p1;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; M-extension sequences run when ALU_MULDIV_EN is defined.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();
  alu_exec_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        br;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        tk;
    logic        il;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input string name, input logic [1:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic br, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic tk,
                              input logic il);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.br = br;
    v.a = a; v.b = b; v.res = res; v.tk = tk; v.il = il;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic br, input logic [31:0] a, input logic [31:0] b);
    bus.alu_op = op;
    bus.func3  = f3;
    bus.func7  = f7;
    bus.branch = br;
    bus.a      = a;
    bus.b      = b;
  endtask

  // Presents one op at the negedge and checks the registered outputs just after the accept edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.op, v.f3, v.f7, v.br, v.a, v.b);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk({v.name, " out_valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({v.name, " result"}, bus.result, v.res);
    chk({v.name, " taken"}, {31'b0, bus.branch_taken}, {31'b0, v.tk});
    chk({v.name, " illegal"}, {31'b0, bus.illegal}, {31'b0, v.il});
  endtask

`ifdef ALU_MULDIV_EN
  task automatic run_m(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int   low;
    logic seen;
    @(negedge clk);
    drive(R_T, f3, FUNC7_MULDIV, 1'b0, a, b);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    low  = 0;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (!bus.in_ready) low++;
      if (bus.out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk({name, " done"}, {31'b0, seen}, 32'd1);
    chk({name, " busy cycles"}, low, 32'd32);
    chk({name, " result"}, bus.result, exp);
    chk({name, " illegal"}, {31'b0, bus.illegal}, 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;

    tbl.push_back(mk("ADD",      R_T, F3_ADD,  FUNC7_BASE, 0, 32'd5, 32'd7, 32'd12, 0, 0));
    tbl.push_back(mk("SUB",      R_T, F3_ADD,  FUNC7_ALT,  0, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0));
    tbl.push_back(mk("BLTU",     B_T, F3_BLTU, FUNC7_BASE, 1, 32'd1, 32'hFFFF_FFFF, 32'd2, 1, 0));
    tbl.push_back(mk("BLT",      B_T, F3_BLT,  FUNC7_BASE, 1, 32'd1, 32'hFFFF_FFFF, 32'd2, 0, 0));
    tbl.push_back(mk("B010",     B_T, 3'b010,  FUNC7_BASE, 1, 32'd1, 32'd1, 32'd0, 0, 1));
    tbl.push_back(mk("B011",     B_T, 3'b011,  FUNC7_BASE, 1, 32'd3, 32'd1, 32'd0, 0, 1));
    tbl.push_back(mk("SRAI",     I_T, F3_SR,   FUNC7_ALT,  0, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0));
    tbl.push_back(mk("SRLI",     I_T, F3_SR,   FUNC7_BASE, 0, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 0));
    tbl.push_back(mk("SLT",      R_T, F3_SLT,  FUNC7_BASE, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0));
    tbl.push_back(mk("SLTU",     R_T, F3_SLTU, FUNC7_BASE, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0));
    tbl.push_back(mk("XOR",      R_T, F3_XOR,  FUNC7_BASE, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0));
    tbl.push_back(mk("ORI",      I_T, F3_OR,   FUNC7_BASE, 0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0, 0));
    tbl.push_back(mk("AND",      R_T, F3_AND,  FUNC7_BASE, 0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 0, 0));
    tbl.push_back(mk("SLL",      R_T, F3_SLL,  FUNC7_BASE, 0, 32'd1, 32'h23, 32'd8, 0, 0));
    tbl.push_back(mk("SRA",      R_T, F3_SR,   FUNC7_ALT,  0, 32'hFFFF_FF00, 32'd4, 32'hFFFF_FFF0, 0, 0));
    tbl.push_back(mk("LDST",     S_T, 3'b010,  FUNC7_BASE, 0, 32'h100, 32'hFFFF_FFFC, 32'h0000_00FC, 0, 0));
    tbl.push_back(mk("BEQ",      B_T, F3_BEQ,  FUNC7_BASE, 1, 32'd5, 32'd5, 32'd0, 1, 0));
    tbl.push_back(mk("BNE",      B_T, F3_BNE,  FUNC7_BASE, 1, 32'd5, 32'd5, 32'd0, 0, 0));
    tbl.push_back(mk("BGE",      B_T, F3_BGE,  FUNC7_BASE, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1, 0));
    tbl.push_back(mk("BGEU",     B_T, F3_BGEU, FUNC7_BASE, 1, 32'd1, 32'd2, 32'hFFFF_FFFF, 0, 0));
    tbl.push_back(mk("BEQ nobr", B_T, F3_BEQ,  FUNC7_BASE, 0, 32'd9, 32'd9, 32'd0, 0, 0));
    tbl.push_back(mk("R f7bad",  R_T, F3_ADD,  7'b0000010, 0, 32'd5, 32'd7, 32'd0, 0, 1));
    tbl.push_back(mk("XOR alt",  R_T, F3_XOR,  FUNC7_ALT,  0, 32'd5, 32'd7, 32'd0, 0, 1));
    tbl.push_back(mk("ADD wrap", R_T, F3_ADD,  FUNC7_BASE, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0));
    tbl.push_back(mk("ADDI b5",  I_T, F3_ADD,  FUNC7_ALT,  0, 32'd5, 32'd7, 32'd12, 0, 0));

    // Reset with an op presented: rst wins and nothing is accepted.
    rst = 1'b1;
    bus.in_valid = 1'b1;
    drive(R_T, F3_ADD, FUNC7_BASE, 1'b0, 32'd1, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset taken", {31'b0, bus.branch_taken}, 32'd0);
    chk("reset illegal", {31'b0, bus.illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Back-to-back: in_valid stays high across the whole table.
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("out_valid not held", {31'b0, bus.out_valid}, 32'd0);

`ifdef ALU_MULDIV_EN
    run_m("MUL",    F3_MUL,   32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    run_vec(mk("ADD after MUL", R_T, F3_ADD, FUNC7_BASE, 0, 32'd2, 32'd3, 32'd5, 0, 0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    run_m("MULH",   F3_MULH,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF);
    run_m("MULHU",  F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_m("DIV/0",  F3_DIV,   32'd7, 32'd0, 32'hFFFF_FFFF);
    run_m("REM/0",  F3_REM,   32'd7, 32'd0, 32'd7);
    run_m("DIVovf", F3_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_m("DIVneg", F3_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_m("REMneg", F3_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_m("DIVU",   F3_DIVU,  32'd100, 32'd7, 32'd14);

    // Abort a DIVU with reset ten cycles in.
    @(negedge clk);
    drive(R_T, F3_DIVU, FUNC7_MULDIV, 1'b0, 32'd100, 32'd7);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("abort out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) pulses++;
    end
    chk("abort no output", pulses, 32'd0);
    run_vec(mk("ADD after abort", R_T, F3_ADD, FUNC7_BASE, 0, 32'd5, 32'd7, 32'd12, 0, 0));
    @(negedge clk);
    bus.in_valid = 1'b0;
`else
    run_vec(mk("M off", R_T, F3_MUL, FUNC7_MULDIV, 0, 32'd5, 32'd7, 32'd0, 0, 1));
    chk("M off in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("M off in_ready after", {31'b0, bus.in_ready}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised successor to the single-cycle ALU controller. It merges ALU-op decode, execution and full RV32 branch resolution into one registered execute stage. It also adds an optional iterative multiply/divide engine (M extension) behind a valid/ready handshake, so the core stalls on in_ready while a multi-cycle op runs. It sits between the register-file read stage and writeback/PC-select.

## Interface
- XLEN, 32: datapath width; power of two, ≥ 8.
- SHW, $clog2(XLEN): shift-amount width (derived).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept; the op is accepted on an edge where in_valid & in_ready.
- alu_op  in  2  10 R-type, 11 I-type, 00 load/store, 01 branch.
- func3  in  3  instruction funct3.
- func7  in  7  instruction funct7; I-type uses only bit 5 (SRAI).
- branch  in  1  instruction is a branch.
- a, b  in  XLEN  operands; b is the immediate for I/S types.
- out_valid  out  1  one-cycle pulse; result, branch_taken and illegal are valid.
- result  out  XLEN  registered ALU result.
- branch_taken  out  1  registered branch decision.
- illegal  out  1  unsupported encoding flag, qualified by out_valid.

## Operation
- States: IDLE, BUSY.
- In IDLE, in_ready=1. In BUSY, in_ready=0 and in_valid is ignored.
- R-type, func3 (func7[5]):
  - 000 ADD/SUB(1)
  - 001 SLL
  - 010 SLT
  - 011 SLTU
  - 100 XOR
  - 101 SRL/SRA(1)
  - 110 OR
  - 111 AND
- I-type uses the same table. func3 000 is always ADD. For 001/101, func7[5] selects SRAI.
- Shifts use b[SHW-1:0]. SRA is arithmetic.
- SLT/SLTU return a zero-extended 0/1.
- Load/store (00): result = a + b.
- Branch (01): result = a − b. Comparisons are computed internally, not from zero/sign flags.
  - branch_taken = branch & cond, with func3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - func3 010/011: illegal=1, taken=0.
- Non-branch ops: branch_taken=0.
- Arithmetic wraps modulo 2^XLEN; there are no overflow flags.
- Illegal encodings (unlisted func7 values on R-type, bad branch func3) give result=0, illegal=1, out_valid on the normal 1-cycle path.
- M ops (R-type, func7=0000001, macro on): func3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Signed ops use magnitude conversion, then sign correction.
  - DIV/DIVU by zero: quotient all-ones, remainder = a.
  - DIV overflow (−2^(XLEN−1) / −1): quotient = a, remainder 0.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, result=0, branch_taken=0, illegal=0, counter=0.
- Simple ops: accept at edge E0; outputs registered at E0; out_valid=1 for exactly the following cycle. Back-to-back accepts give throughput 1/cycle.
- M ops: accept at E0 → BUSY, counter=XLEN−1.
  - One radix-2 iteration (shift-add or restoring subtract) per edge E1..E_XLEN.
  - At E_XLEN: result latched, state → IDLE, out_valid=1 in the next cycle, in_ready=1 in that same cycle.
  - in_ready is low for exactly XLEN cycles.
- A new op may be accepted in the cycle out_valid is high.
- No backpressure on the output: out_valid is not held.
- rst in BUSY: abort. Next cycle is IDLE with out_valid=0; the aborted op produces no output.
- rst and in_valid asserted together: rst wins and the op is not accepted.

## Configuration
- ALU_MULDIV_EN defined: M-op decode, muldiv_iter instance and BUSY path are compiled in.
- ALU_MULDIV_EN undefined: func7=0000001 on R-type is illegal (result 0, illegal=1, latency 1). The BUSY state is unreachable and in_ready is tied to 1.

## Structure
- Package alu_pkg holds:
  - alu_op encodings R_T, I_T, S_T, B_T
  - func3 constants for ALU, branch and M ops
  - FUNC7_MULDIV = 7'b0000001
  - the state enum {IDLE, BUSY}
- Sub-module muldiv_iter(XLEN) holds the iterative engine: start/done, op select, a, b → XLEN result, with its own counter.
- The top level keeps decode, the single-cycle ALU, branch compare, the state machine and output registers.

## Test plan
- Reset, then ADD a=5,b=7 → next cycle out_valid=1, result=12; then SUB(func7[5]=1) a=5,b=7 → result=0xFFFFFFFE.
- Branch BLTU a=1,b=0xFFFFFFFF, branch=1 → taken=1. BLT with the same operands → taken=0. func3=010 → illegal=1, taken=0.
- SRAI a=0x80000000, b=4, func7[5]=1 → 0xF8000000. SRLI → 0x08000000.
- MUL a=−3,b=7 (macro on) → in_ready low 32 cycles, then out_valid with result=0xFFFFFFEB. DIV a=7,b=0 → 0xFFFFFFFF. REM a=7,b=0 → 7. DIV 0x80000000/−1 → 0x80000000.
- DIVU started, rst asserted at cycle 10 → next cycle IDLE, out_valid never pulses for the op; a following ADD completes normally.
- Macro off: R-type func7=0000001 → latency 1, illegal=1, result=0, in_ready stays 1.
